// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and default timing for the PLL lock supervisor.
// Holds the FSM state enum, default cycle counts and the loss-count width.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    LOCKED    = 3'd3,
    LOST      = 3'd4
  } pll_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 50000;
  localparam int DEF_LOSS_CYCLES    = 4;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES = 500000;
  localparam int DEF_CNT_W          = 20;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop single-bit synchroniser, synchronous active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies raw PLL lock, drives PLL reset and system reset.
// Ports: init_clk, rst_n (sync, active low), pll_lock (async) in;
//   pll_rst, sys_rst_n, clk_ok, relock_pulse, state_o out.
//   loss_count (saturating loss tally) exists only with LOCK_LOSS_COUNTER_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int LOSS_CYCLES    = DEF_LOSS_CYCLES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                  init_clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  clk_ok,
  output logic                  relock_pulse,
`ifdef LOCK_LOSS_COUNTER_EN
  output logic [LOSS_CNT_W-1:0] loss_count,
`endif
  output logic [2:0]            state_o
);

  localparam int LW = $clog2(LOSS_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_RST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STAB = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0]    C_LOSS = LW'(LOSS_CYCLES);

  pll_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [LW-1:0]    loss_cnt;
  logic             lock_s;

  sync_bit #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk   (init_clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_ff @(posedge init_clk) begin
    if (!rst_n) begin
      state        <= RST_PLL;
      cnt          <= C_RST;
      loss_cnt     <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      clk_ok       <= 1'b0;
      relock_pulse <= 1'b0;
    end else begin
      relock_pulse <= 1'b0;
      loss_cnt     <= '0;
      case (state)
        RST_PLL: begin
          if (cnt == '0) begin
            state   <= WAIT_LOCK;
            cnt     <= C_TO;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock beats a timeout expiring on the same cycle
          if (lock_s) begin
            state <= QUALIFY;
            cnt   <= C_STAB;
          end else if (cnt == '0) begin
            state   <= RST_PLL;
            cnt     <= C_RST;
            pll_rst <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        QUALIFY: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= C_TO;
          end else if (cnt == '0) begin
            state     <= LOCKED;
            sys_rst_n <= 1'b1;
            clk_ok    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOCKED: begin
          if (loss_cnt == C_LOSS) begin
            state        <= LOST;
            sys_rst_n    <= 1'b0;
            clk_ok       <= 1'b0;
            relock_pulse <= 1'b1;
          end else if (!lock_s) begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end
        LOST: begin
          state   <= RST_PLL;
          cnt     <= C_RST;
          pll_rst <= 1'b1;
        end
        default: begin
          state     <= RST_PLL;
          cnt       <= C_RST;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          clk_ok    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCK_LOSS_COUNTER_EN
  always_ff @(posedge init_clk) begin
    if (!rst_n) begin
      loss_count <= '0;
    end else if (state == LOCKED && loss_cnt == C_LOSS
                 && loss_count != '1) begin
      loss_count <= loss_count + 1'b1;
    end
  end
`endif

  assign state_o = state;

endmodule
